// File: rtl/nibble_word_assembler.sv
// Nibble-serial receiver: collects 4-bit nibbles (LSB- or MSB-first) into a word,
// applies zero/sign fill to unreceived positions and presents it on a valid/ready port.
module nibble_word_assembler #(
    parameter int NIBBLES = 8,
    parameter int IDX_W   = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 reverse_direction,
    input  logic [IDX_W-1:0]     last_idx,
    input  logic                 sign_extend,
    input  logic                 nib_valid,
    input  logic [3:0]           nib_data,
    output logic                 nib_ready,
    output logic                 word_valid,
    input  logic                 word_ready,
    output logic [4*NIBBLES-1:0] word,
    output logic                 busy
);

    localparam int WORD_W = 4 * NIBBLES;

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        HOLD
    } state_t;

    state_t            state_q, state_d;
    logic [WORD_W-1:0] acc_q, acc_d;
    logic [WORD_W-1:0] word_q, word_d;
    logic [IDX_W-1:0]  cnt_q, cnt_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [IDX_W-1:0]  last_q, last_d;
    logic              rev_q, rev_d;
    logic              sext_q, sext_d;

    logic [WORD_W-1:0] merged;
    logic [WORD_W-1:0] fill;
    logic              load_cfg;

    // NOTE: every variable assigned in this block gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        word_d   = word_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        last_d   = last_q;
        rev_d    = rev_q;
        sext_d   = sext_q;
        load_cfg = 1'b0;

        merged = acc_q;
        merged[{idx_q, 2'b00} +: 4] = nib_data;

        // Unreceived positions are already zero (accumulator cleared on start),
        // so only the sign-extension ones need to be ORed in.
        fill = '0;
        for (int i = 0; i < NIBBLES; i++) begin
            if (!rev_q && sext_q && nib_data[3] && ((IDX_W+1)'(i) > {1'b0, last_q}))
                fill[4*i +: 4] = 4'hF;
        end

        unique case (state_q)
            IDLE: begin
                if (start)
                    load_cfg = 1'b1;
            end
            COLLECT: begin
                if (nib_valid) begin
                    acc_d = merged;
                    cnt_d = cnt_q + 1'b1;
                    idx_d = rev_q ? idx_q - 1'b1 : idx_q + 1'b1;
                    if (cnt_q == last_q) begin
                        word_d  = merged | fill;
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                if (word_ready) begin
                    state_d = IDLE;
                    if (start)
                        load_cfg = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // A new word can start from IDLE or straight out of a completed HOLD.
        if (load_cfg) begin
            rev_d   = reverse_direction;
            last_d  = last_idx;
            sext_d  = sign_extend;
            acc_d   = '0;
            cnt_d   = '0;
            idx_d   = reverse_direction ? IDX_W'(NIBBLES - 1) : '0;
            state_d = COLLECT;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            word_q  <= '0;
            cnt_q   <= '0;
            idx_q   <= '0;
            last_q  <= '0;
            rev_q   <= 1'b0;
            sext_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            word_q  <= word_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
            rev_q   <= rev_d;
            sext_q  <= sext_d;
        end
    end

    assign nib_ready  = (state_q == COLLECT);
    assign word_valid = (state_q == HOLD);
    assign busy       = (state_q != IDLE);
    assign word       = word_q;

endmodule

// File: tb/tb_nibble_word_assembler.sv
// Self-checking bench for nibble_word_assembler: directed test-plan words followed
// by randomized words, all compared against an arithmetic reference model.
module tb_nibble_word_assembler;

    localparam int NIBBLES = 8;
    localparam int IDX_W   = 3;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic              reverse_direction;
    logic [IDX_W-1:0]  last_idx;
    logic              sign_extend;
    logic              nib_valid;
    logic [3:0]        nib_data;
    logic              nib_ready;
    logic              word_valid;
    logic              word_ready;
    logic [31:0]       word;
    logic              busy;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] last_word = '0;

    nibble_word_assembler #(.NIBBLES(NIBBLES), .IDX_W(IDX_W)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .start             (start),
        .reverse_direction (reverse_direction),
        .last_idx          (last_idx),
        .sign_extend       (sign_extend),
        .nib_valid         (nib_valid),
        .nib_data          (nib_data),
        .nib_ready         (nib_ready),
        .word_valid        (word_valid),
        .word_ready        (word_ready),
        .word              (word),
        .busy              (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not reach its summary");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Word built from the rules: k-th arriving nibble lands at position k
    // (LSB-first) or NIBBLES-1-k (MSB-first); LSB-first may sign-fill upward.
    function automatic logic [31:0] model_word(input bit rev, input int last, input bit sext,
                                               input logic [3:0] nibs [NIBBLES]);
        logic [63:0] w;
        w = '0;
        for (int k = 0; k <= last; k++) begin
            int pos = rev ? NIBBLES - 1 - k : k;
            w |= 64'(nibs[k]) << (4 * pos);
        end
        if (!rev && sext && nibs[last][3])
            w |= ~64'd0 << (4 * (last + 1));
        return w[31:0];
    endfunction

    task automatic begin_word(input bit rev, input int last, input bit sext);
        start             = 1'b1;
        reverse_direction = rev;
        last_idx          = IDX_W'(last);
        sign_extend       = sext;
        tick();
        start = 1'b0;
        check("start_nib_ready", nib_ready, 1);
        check("start_busy", busy, 1);
        check("start_word_valid", word_valid, 0);
    endtask

    // Feeds nibbles with random gaps; junk on the config/start/data inputs
    // during gaps must not disturb the word being collected.
    task automatic feed(input logic [3:0] nibs [NIBBLES], input int last, input int max_gap);
        for (int k = 0; k <= last; k++) begin
            int gaps = $urandom_range(max_gap, 0);
            repeat (gaps) begin
                nib_valid         = 1'b0;
                nib_data          = 4'($urandom);
                start             = 1'($urandom);
                reverse_direction = 1'($urandom);
                last_idx          = IDX_W'($urandom);
                sign_extend       = 1'($urandom);
                tick();
                check("gap_nib_ready", nib_ready, 1);
                check("gap_word_valid", word_valid, 0);
            end
            nib_valid = 1'b1;
            nib_data  = nibs[k];
            tick();
            if (k < last) begin
                check("collect_word_valid", word_valid, 0);
                check("collect_word_kept", word, last_word);
            end
        end
        nib_valid = 1'b0;
        start     = 1'b0;
    endtask

    task automatic hold_and_release(input string tag, input logic [31:0] exp, input int stall);
        check({tag, "_valid"}, word_valid, 1);
        check({tag, "_nib_ready"}, nib_ready, 0);
        check({tag, "_busy"}, busy, 1);
        check(tag, word, exp);
        repeat (stall) begin
            word_ready = 1'b0;
            tick();
            check({tag, "_stall_valid"}, word_valid, 1);
            check({tag, "_stall_word"}, word, exp);
        end
        word_ready = 1'b1;
        tick();
        word_ready = 1'b0;
        check({tag, "_released"}, word_valid, 0);
        check({tag, "_idle_busy"}, busy, 0);
        check({tag, "_idle_nib_ready"}, nib_ready, 0);
        check({tag, "_word_kept"}, word, exp);
        last_word = exp;
    endtask

    initial begin
        logic [3:0]  nibs [NIBBLES];
        logic [31:0] exp;

        rst_n             = 1'b0;
        start             = 1'b0;
        reverse_direction = 1'b0;
        last_idx          = '0;
        sign_extend       = 1'b0;
        nib_valid         = 1'b0;
        nib_data          = '0;
        word_ready        = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_nib_ready", nib_ready, 0);
        check("reset_word_valid", word_valid, 0);
        check("reset_busy", busy, 0);
        check("reset_word", word, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // LSB-first full word, top nibble only
        nibs = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'hF};
        exp  = model_word(0, 7, 0, nibs);
        check("model_lsb_full", exp, 32'hF000_0000);
        begin_word(0, 7, 0);
        feed(nibs, 7, 0);
        hold_and_release("lsb_full", exp, 0);

        // MSB-first full word
        nibs = '{4'h0, 4'h6, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
        exp  = model_word(1, 7, 0, nibs);
        begin_word(1, 7, 0);
        feed(nibs, 7, 0);
        hold_and_release("msb_full", exp, 0);

        // Short LSB-first words with and without sign extension
        nibs = '{4'h1, 4'h0, 4'h9, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
        exp  = model_word(0, 2, 1, nibs);
        begin_word(0, 2, 1);
        feed(nibs, 2, 0);
        hold_and_release("lsb_sext", exp, 0);
        exp = model_word(0, 2, 0, nibs);
        begin_word(0, 2, 0);
        feed(nibs, 2, 0);
        hold_and_release("lsb_zext", exp, 0);

        // Short MSB-first word with gaps; sign_extend must be ignored
        nibs = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h0, 4'h0, 4'h0, 4'h0};
        exp  = model_word(1, 3, 1, nibs);
        begin_word(1, 3, 1);
        feed(nibs, 3, 3);
        hold_and_release("msb_short_gaps", exp, 0);

        // Backpressure, then back-to-back start on the releasing cycle
        nibs = '{4'h5, 4'hA, 4'h3, 4'hC, 4'h7, 4'h1, 4'hE, 4'h2};
        exp  = model_word(0, 7, 0, nibs);
        begin_word(0, 7, 0);
        feed(nibs, 7, 0);
        check("b2b_a_valid", word_valid, 1);
        repeat (5) begin
            word_ready = 1'b0;
            tick();
            check("b2b_a_stall_valid", word_valid, 1);
            check("b2b_a_stall_word", word, exp);
        end
        word_ready        = 1'b1;
        start             = 1'b1;
        reverse_direction = 1'b1;
        last_idx          = IDX_W'(4);
        sign_extend       = 1'b0;
        tick();
        start      = 1'b0;
        word_ready = 1'b0;
        check("b2b_no_idle_nib_ready", nib_ready, 1);
        check("b2b_no_idle_busy", busy, 1);
        check("b2b_no_idle_valid", word_valid, 0);
        check("b2b_a_word_kept", word, exp);
        last_word = exp;
        nibs = '{4'h9, 4'h8, 4'h7, 4'h6, 4'h5, 4'h0, 4'h0, 4'h0};
        exp  = model_word(1, 4, 0, nibs);
        feed(nibs, 4, 1);
        hold_and_release("b2b_b", exp, 0);

        // Asynchronous reset in the middle of a word
        begin_word(0, 7, 0);
        for (int k = 0; k < 3; k++) begin
            nib_valid = 1'b1;
            nib_data  = 4'hA;
            tick();
        end
        nib_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_nib_ready", nib_ready, 0);
        check("async_rst_busy", busy, 0);
        check("async_rst_word_valid", word_valid, 0);
        check("async_rst_word", word, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        last_word = '0;
        nibs = '{4'hF, 4'hE, 4'hD, 4'hC, 4'hB, 4'hA, 4'h9, 4'h8};
        exp  = model_word(0, 7, 0, nibs);
        check("model_after_reset", exp, 32'h89AB_CDEF);
        begin_word(0, 7, 0);
        feed(nibs, 7, 0);
        hold_and_release("after_reset", exp, 0);

        // Randomized words
        for (int t = 0; t < 24; t++) begin
            bit rev  = 1'($urandom);
            bit sext = 1'($urandom);
            int last = $urandom_range(NIBBLES - 1, 0);
            for (int k = 0; k < NIBBLES; k++)
                nibs[k] = 4'($urandom);
            exp = model_word(rev, last, sext, nibs);
            begin_word(rev, last, sext);
            feed(nibs, last, 2);
            hold_and_release("random_word", exp, $urandom_range(3, 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
